// File: rtl/ps2_kbd_rx_if.sv
// Event-queue bus between the PS/2 receiver (master) and its consumer (slave).
// The consumer pops with rd_en and clears the sticky overflow flag with clr_ovf.
interface ps2_kbd_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          clr_ovf;
    logic          ev_valid;
    logic [7:0]    ev_code;
    logic          ev_ext;
    logic          ev_break;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        input  rd_en, clr_ovf,
        output ev_valid, ev_code, ev_ext, ev_break, fifo_count, overflow
    );

    modport slave (
        output rd_en, clr_ovf,
        input  ev_valid, ev_code, ev_ext, ev_break, fifo_count, overflow
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver with E0/F0 prefix decode into a show-ahead event FIFO; ev_valid rises 1 cycle after the stop-bit edge.
// No backpressure to the keyboard: a full FIFO drops the event and sets overflow. PS2_KBD_RX_MAKE_EN also queues make codes.
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_ps2clk,
    input  logic          i_ps2data,
    ps2_kbd_rx_if.master  io_ev,
    output logic          o_err_parity,
    output logic          o_err_frame
);
    localparam int HALF = FILTER_LEN / 2;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int TW   = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic                  r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  w_fall;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_bitcnt, w_bitcnt_nxt;
    logic [7:0]            r_shift, w_shift_nxt;
    logic                  r_par, w_par_nxt;
    logic [TW-1:0]         r_tcnt, w_tcnt_nxt;
    logic                  r_ext, w_ext_nxt;
    logic                  r_brk, w_brk_nxt;
    logic                  w_push, w_err_par, w_err_frm;

    logic [9:0]            r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  w_empty, w_full, w_do_push, w_do_pop, w_drop;
    logic [9:0]            w_head;

    // Synchronisers and filter idle high so reset never looks like a falling edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= '1;
        end else begin
            r_clk_s1 <= i_ps2clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2data;
            r_dat_s2 <= r_dat_s1;
            r_filt   <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
        end
    end

    assign w_fall = (&r_filt[FILTER_LEN-1:HALF]) & ~(|r_filt[HALF-1:0]);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_tcnt   <= '0;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par    <= w_par_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_ext    <= w_ext_nxt;
            r_brk    <= w_brk_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_par_nxt    = r_par;
        w_tcnt_nxt   = r_tcnt;
        w_ext_nxt    = r_ext;
        w_brk_nxt    = r_brk;
        w_push       = 1'b0;
        w_err_par    = 1'b0;
        w_err_frm    = 1'b0;

        if (r_state != S_IDLE) begin
            w_tcnt_nxt = r_tcnt + TW'(1);
        end

        if (w_fall) begin
            w_tcnt_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt  = S_DATA;
                        w_bitcnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    w_shift_nxt  = {r_dat_s2, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_par_nxt   = r_dat_s2;
                    w_state_nxt = S_STOP;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    // A bad stop bit is reported as a framing error even if parity also fails.
                    if (!r_dat_s2) begin
                        w_err_frm = 1'b1;
                        w_ext_nxt = 1'b0;
                        w_brk_nxt = 1'b0;
                    end else if (^{r_shift, r_par} == 1'b0) begin
                        w_err_par = 1'b1;
                        w_ext_nxt = 1'b0;
                        w_brk_nxt = 1'b0;
                    end else if (r_shift == 8'hE0) begin
                        w_ext_nxt = 1'b1;
                    end else if (r_shift == 8'hF0) begin
                        w_brk_nxt = 1'b1;
                    end else begin
`ifdef PS2_KBD_RX_MAKE_EN
                        w_push = 1'b1;
`else
                        w_push = r_brk;
`endif
                        w_ext_nxt = 1'b0;
                        w_brk_nxt = 1'b0;
                    end
                end
            endcase
        end else if (r_state != S_IDLE && r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
            w_state_nxt = S_IDLE;
            w_tcnt_nxt  = '0;
            w_err_frm   = 1'b1;
            w_ext_nxt   = 1'b0;
            w_brk_nxt   = 1'b0;
        end
    end

    assign o_err_parity = w_err_par;
    assign o_err_frame  = w_err_frm;

    // A pop in the same cycle frees the slot, so a push into a full queue is not a drop.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_do_pop  = io_ev.rd_en & ~w_empty;
    assign w_do_push = w_push & (~w_full | w_do_pop);
    assign w_drop    = w_push & w_full & ~w_do_pop;

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= {r_ext, r_brk, r_shift};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (io_ev.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_head           = r_mem[r_rptr];
    assign io_ev.ev_valid   = ~w_empty;
    assign io_ev.ev_code    = w_empty ? 8'h00 : w_head[7:0];
    assign io_ev.ev_break   = w_empty ? 1'b0  : w_head[8];
    assign io_ev.ev_ext     = w_empty ? 1'b0  : w_head[9];
    assign io_ev.fifo_count = r_count;
    assign io_ev.overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: frame table with scoreboard, plus latency, timeout, overflow and reset sequences.
module tb_ps2_kbd_rx;
    localparam int FL    = 8;
    localparam int DEPTH = 4;
    localparam int TOUT  = 100;
    localparam int HP    = 10;
`ifdef PS2_KBD_RX_MAKE_EN
    localparam bit MAKE_EN = 1'b1;
`else
    localparam bit MAKE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2clk = 1'b1;
    logic ps2data = 1'b1;
    logic err_par, err_frm;

    ps2_kbd_rx_if #(.FIFO_DEPTH(DEPTH)) ev_if ();

    ps2_kbd_rx #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_ps2clk     (ps2clk),
        .i_ps2data    (ps2data),
        .io_ev        (ev_if.master),
        .o_err_parity (err_par),
        .o_err_frame  (err_frm)
    );

    always #5 clk = ~clk;

    int n_par_pulses = 0;
    int n_frm_pulses = 0;
    always @(negedge clk) begin
        if (err_par) n_par_pulses = n_par_pulses + 1;
        if (err_frm) n_frm_pulses = n_frm_pulses + 1;
    end

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        int         exp_par;
        int         exp_frm;
        int         kind;     // 0 none, 1 break event, 2 make event
        logic       ext;
        logic       brk;
    } vec_t;

    ev_t  sb[$];
    bit   exp_ovf = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    vec_t vt[21];

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2data = b;
        wait_cyc(HP);
        ps2clk = 1'b0;
        wait_cyc(HP);
        ps2clk = 1'b1;
    endtask

    // Sends the first nbits of an 11-bit frame; the last one is left with ps2clk just driven low.
    task automatic send_bits(input logic [7:0] code, input logic bad_par, input logic bad_stop,
                             input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits - 1; i++) ps2_bit(fr[i]);
        ps2data = fr[nbits-1];
        wait_cyc(HP);
        ps2clk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
        send_bits(code, bad_par, bad_stop, 11);
        wait_cyc(HP);
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        wait_cyc(HP);
    endtask

    task automatic exp_push(input logic ext, input logic brk, input logic [7:0] code);
        ev_t e;
        e.ext = ext;
        e.brk = brk;
        e.code = code;
        if (sb.size() < DEPTH) sb.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic drain();
        ev_t e;
        chk("fifo_count", int'(ev_if.fifo_count), sb.size());
        chk("overflow", int'(ev_if.overflow), int'(exp_ovf));
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (!ev_if.ev_valid) break;
            if (sb.size() == 0) begin
                chk("unexpected_event", int'(ev_if.ev_valid), 0);
                break;
            end
            e = sb.pop_front();
            chk("ev_code", int'(ev_if.ev_code), int'(e.code));
            chk("ev_ext", int'(ev_if.ev_ext), int'(e.ext));
            chk("ev_break", int'(ev_if.ev_break), int'(e.brk));
            ev_if.rd_en = 1'b1;
            @(negedge clk);
            ev_if.rd_en = 1'b0;
        end
        chk("missing_events", sb.size(), 0);
        chk("ev_valid_after_drain", int'(ev_if.ev_valid), 0);
        sb.delete();
    endtask

    initial begin
        int p0, f0, first, lat;
        ev_if.rd_en   = 1'b0;
        ev_if.clr_ovf = 1'b0;

        vt[0]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[1]  = '{8'h75, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b1};
        vt[2]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[3]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[4]  = '{8'h74, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b1};
        vt[5]  = '{8'h6B, 1'b0, 1'b0, 0, 0, 2, 1'b0, 1'b0};
        vt[6]  = '{8'h2B, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0};
        vt[7]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[8]  = '{8'h2B, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b1};
        vt[9]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[10] = '{8'h29, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0};
        vt[11] = '{8'h29, 1'b0, 1'b0, 0, 0, 2, 1'b0, 1'b0};
        vt[12] = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[13] = '{8'h1C, 1'b0, 1'b1, 0, 1, 0, 1'b0, 1'b0};
        vt[14] = '{8'h1C, 1'b0, 1'b0, 0, 0, 2, 1'b0, 1'b0};
        vt[15] = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[16] = '{8'h1D, 1'b1, 1'b1, 0, 1, 0, 1'b0, 1'b0};
        vt[17] = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[18] = '{8'h5A, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b1};
        vt[19] = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
        vt[20] = '{8'h71, 1'b0, 1'b0, 0, 0, 2, 1'b1, 1'b0};

        // Reset state
        wait_cyc(3);
        chk("rst_ev_valid", int'(ev_if.ev_valid), 0);
        chk("rst_fifo_count", int'(ev_if.fifo_count), 0);
        chk("rst_overflow", int'(ev_if.overflow), 0);
        chk("rst_err", int'({err_par, err_frm}), 0);
        rst_n = 1'b1;
        wait_cyc(HP);

        // First-event latency: ev_valid rises the cycle after the stop-bit edge is recognised.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_bits(8'h75, 1'b0, 1'b0, 11);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ev_if.ev_valid && lat == 0) lat = k;
        end
        chk("push_latency", lat, 2 + FL / 2 + 1);
        ps2clk = 1'b1;
        wait_cyc(HP);
        exp_push(1'b0, 1'b1, 8'h75);
        drain();

        // Table-driven frames
        for (int i = 0; i < 21; i++) begin
            p0 = n_par_pulses;
            f0 = n_frm_pulses;
            send_frame(vt[i].code, vt[i].bad_par, vt[i].bad_stop);
            chk($sformatf("vec%0d_err_parity", i), n_par_pulses - p0, vt[i].exp_par);
            chk($sformatf("vec%0d_err_frame", i), n_frm_pulses - f0, vt[i].exp_frm);
            if (vt[i].kind == 1 || (vt[i].kind == 2 && MAKE_EN))
                exp_push(vt[i].ext, vt[i].brk, vt[i].code);
            drain();
        end

        // Timeout after four data bits
        p0 = n_par_pulses;
        f0 = n_frm_pulses;
        send_bits(8'h3C, 1'b0, 1'b0, 5);
        first = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (err_frm && first == 0) first = k;
        end
        chk("timeout_cycle", first, 2 + FL / 2 + TOUT);
        chk("timeout_frame_pulses", n_frm_pulses - f0, 1);
        chk("timeout_parity_pulses", n_par_pulses - p0, 0);
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        wait_cyc(HP);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        exp_push(1'b0, 1'b1, 8'h33);
        drain();

        // Overflow: five break events into a four-deep queue
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h15, 1'b0, 1'b0); exp_push(1'b0, 1'b1, 8'h15);
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h16, 1'b0, 1'b0); exp_push(1'b0, 1'b1, 8'h16);
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h1E, 1'b0, 1'b0); exp_push(1'b0, 1'b1, 8'h1E);
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h26, 1'b0, 1'b0); exp_push(1'b0, 1'b1, 8'h26);
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h25, 1'b0, 1'b0); exp_push(1'b0, 1'b1, 8'h25);
        chk("full_count", int'(ev_if.fifo_count), DEPTH);
        chk("full_overflow", int'(ev_if.overflow), int'(exp_ovf));
        chk("full_head", int'(ev_if.ev_code), int'(sb[0].code));
        ev_if.clr_ovf = 1'b1;
        @(negedge clk);
        ev_if.clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        chk("clr_ovf", int'(ev_if.overflow), 0);

        // Pop and push in the same cycle while full
        send_frame(8'hF0, 1'b0, 1'b0);
        send_bits(8'h2E, 1'b0, 1'b0, 11);
        wait_cyc(2 + FL / 2);
        ev_if.rd_en = 1'b1;
        @(negedge clk);
        ev_if.rd_en = 1'b0;
        void'(sb.pop_front());
        exp_push(1'b0, 1'b1, 8'h2E);
        chk("pushpop_count", int'(ev_if.fifo_count), DEPTH);
        chk("pushpop_overflow", int'(ev_if.overflow), 0);
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        wait_cyc(HP);
        drain();

        // Pop while empty is ignored
        ev_if.rd_en = 1'b1;
        @(negedge clk);
        ev_if.rd_en = 1'b0;
        chk("empty_pop_count", int'(ev_if.fifo_count), 0);

        // Reset in the middle of DATA with two events queued
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h4B, 1'b0, 1'b0); exp_push(1'b0, 1'b1, 8'h4B);
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h4C, 1'b0, 1'b0); exp_push(1'b0, 1'b1, 8'h4C);
        chk("prereset_count", int'(ev_if.fifo_count), 2);
        send_bits(8'h55, 1'b0, 1'b0, 4);
        wait_cyc(2);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", int'(ev_if.ev_valid), 0);
        wait_cyc(2);
        chk("rst_mid_outputs",
            int'({ev_if.ev_valid, ev_if.ev_code, ev_if.ev_ext, ev_if.ev_break,
                  ev_if.fifo_count, ev_if.overflow, err_par, err_frm}), 0);
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        wait_cyc(5);
        rst_n = 1'b1;
        sb.delete();
        exp_ovf = 1'b0;
        wait_cyc(2 * HP);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h72, 1'b0, 1'b0);
        exp_push(1'b0, 1'b1, 8'h72);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Parametrised PS/2 keyboard receiver with prefix decoding and a buffered event queue. It sits between the PS/2 pins and the display/control logic, on the 25 MHz pixel clock domain. Compared with the single-register scancode receiver it replaces, it adds:
- input synchronisation and a configurable edge filter;
- an inter-bit timeout;
- E0/F0 prefix tracking;
- a FIFO so that consecutive key events are not lost.

## Interface
- FILTER_LEN, 8: ps2clk sample-window length; must be even and ≥4.
- FIFO_DEPTH, 8: event queue depth; must be a power of two and ≥2.
- TIMEOUT_CYC, 20000: clock cycles allowed between ps2clk falling edges inside a frame.
- clock  in  1  system clock, one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ps2clk  in  1  raw PS/2 clock pin; asynchronous to clock.
- ps2data  in  1  raw PS/2 data pin; asynchronous to clock.
- rd_en  in  1  pops the head event when ev_valid=1.
- clr_ovf  in  1  clears overflow.
- ev_valid  out  1  FIFO not empty.
- ev_code  out  8  scancode of the head event.
- ev_ext  out  1  head event was preceded by an E0 prefix.
- ev_break  out  1  head event was preceded by an F0 prefix (key release).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of events queued.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- err_parity  out  1  one-cycle pulse on a parity failure.
- err_frame  out  1  one-cycle pulse on a bad start/stop bit or a timeout.

## Operation
- **Synchronisation:** ps2clk and ps2data each pass through a 2-flop synchroniser. All logic below uses the synchronised copies.
- **Edge detection:** a FILTER_LEN-bit shift register holds ps2clk samples. fall_edge=1 when the older FILTER_LEN/2 samples are all 1 and the newer FILTER_LEN/2 samples are all 0. fall_edge is a one-cycle strobe.
- **Frame FSM:** on each fall_edge, ps2data is sampled.
  - IDLE: sampled 0 → DATA with bit counter cleared. Sampled 1 → stay in IDLE, no error.
  - DATA: shift data in LSB-first. After the 8th bit → PARITY.
  - PARITY: store the parity bit → STOP.
  - STOP: validate the frame, then → IDLE.
- **Frame validation:**
  - Stop bit must be 1, otherwise pulse err_frame.
  - Odd parity over data plus parity bit, otherwise pulse err_parity.
  - If both checks fail, err_frame takes precedence and only err_frame pulses.
  - A bad frame is discarded and clears the ext and brk prefix flags.
- **Timeout:** a counter runs in every state except IDLE and is cleared by each fall_edge. When it reaches TIMEOUT_CYC-1: FSM → IDLE, err_frame pulses, prefix flags clear. The partial frame is discarded.
- **Prefix decode on a good frame:**
  - Code E0: set ext, push nothing.
  - Code F0: set brk, push nothing.
  - Any other code: push {ext, brk, code} subject to the Configuration rule, then clear ext and brk.
- **FIFO:** show-ahead. ev_code, ev_ext and ev_break reflect the head whenever ev_valid=1.
  - rd_en while empty is ignored.
  - Push while full: the new event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both happen and overflow is not set.
  - Push and pop in the same cycle while empty: the push takes effect and the pop is ignored.
- **overflow clearing:** cleared by clr_ovf. If clr_ovf and a drop occur in the same cycle, the set wins.
- **Reset:** reset_n low at any time (including mid-frame) forces the following immediately and asynchronously:
  - FSM to IDLE, counters to 0, prefix flags to 0, FIFO empty;
  - synchronisers and edge filter to all 1s, i.e. idle-high;
  - outputs: ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, fifo_count=0, overflow=0, err_parity=0, err_frame=0.

## Timing
- A ps2clk falling edge is recognised (fall_edge=1) 2 + FILTER_LEN/2 cycles after the pin changes, given a clean signal.
- Frame validation happens in the cycle where fall_edge=1 and the FSM is in STOP. In that same cycle a push is issued, or err_parity/err_frame pulses.
- ev_valid rises one cycle after the push, and fifo_count increments on the same edge.
- **Pop:** rd_en=1 at edge N → the next head (or ev_valid=0) is visible after edge N, and fifo_count decrements on that same edge.
- **Throughput:** one event per PS/2 frame. No backpressure toward the keyboard is applied.
- Minimum supported ps2clk low/high phase: FILTER_LEN/2+2 clock cycles.

## Configuration
- PS2_KBD_RX_MAKE_EN defined: make codes (no F0 prefix) are pushed with ev_break=0, and break codes are pushed with ev_break=1.
- PS2_KBD_RX_MAKE_EN undefined: only break codes are pushed, so ev_break is always 1. Make codes are still parsed and checked for errors, then discarded. This is the release-only behaviour.

## Test plan
- Frames F0 then 75 with correct parity, FILTER_LEN=8 → one event: ev_code=75, ev_break=1, ev_ext=0, fifo_count=1. ev_valid rises one cycle after the stop-edge push.
- Frames E0, F0, 74 → one event: ev_code=74, ev_ext=1, ev_break=1. Then frame 6B with the macro defined → a second event: 6B, ext=0, brk=0. With the macro undefined → no second event.
- Frame 2B sent with even parity → err_parity pulses once, no push, and the prefix flags are cleared. A following F0, 2B sequence pushes normally.
- With TIMEOUT_CYC=100, stop ps2clk after 4 data bits → err_frame pulses exactly 100 cycles after the last edge and the FSM is back in IDLE. The next full frame is received correctly.
- With FIFO_DEPTH=4, send 5 break events without rd_en → fifo_count=4, overflow=1, and the head is the first event. Then pop and push in the same cycle while full → count stays 4, no new overflow. clr_ovf → overflow=0.
- Assert reset_n low in the middle of DATA with 2 events queued → all outputs are 0 during reset. After release, a fresh F0, 72 sequence yields exactly one event, 72.
